// File: rtl/fp_mul_scheduler.sv
// Shares one fixed-latency floating-point multiplier between NUM_REQ requesters.
// Round-robin grant is combinational; a response appears MUL_LAT+1 clocks after its grant edge.
// hold stops new grants while in-flight ops drain; responses have no backpressure.
module fp_mul_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   hold,
  output logic [31:0]            mul_in1,
  output logic [31:0]            mul_in2,
  input  logic [31:0]            mul_out,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_data,
  output logic                   idle
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state;
  logic [ID_W-1:0]          last_grant;
  logic [MUL_LAT:0]         tag_vld;
  logic [MUL_LAT:0][ID_W-1:0] tag_id;

  logic                     arb_en;
  logic                     found;
  logic [ID_W-1:0]          grant_id;
  logic                     handshake;
  logic                     pipe_busy;

  assign pipe_busy = |tag_vld;

  // Grants are only offered outside reset and DRAIN, and never while hold is high.
  assign arb_en    = !rst && !hold && (state == IDLE || state == RUN);
  assign handshake = arb_en && found;

  // Round-robin search: first requesters above last_grant, then wrap to the rest.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[j] && (ID_W'(j) > last_grant)) begin
        found    = 1'b1;
        grant_id = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req_valid[j] && (ID_W'(j) <= last_grant)) begin
        found    = 1'b1;
        grant_id = ID_W'(j);
      end
    end
  end

  // One-hot ready for the granted requester; the grant always follows a valid bit.
  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      req_ready[j] = handshake && (grant_id == ID_W'(j));
    end
  end

  // Issue registers and tag pipeline; the tag travels alongside the op through the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_in1    <= '0;
      mul_in2    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      tag_vld    <= '0;
      tag_id     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      tag_vld[0] <= handshake;
      if (handshake) begin
        mul_in1    <= req_a[32*int'(grant_id) +: 32];
        mul_in2    <= req_b[32*int'(grant_id) +: 32];
        last_grant <= grant_id;
        tag_id[0]  <= grant_id;
      end
      for (int i = 1; i <= MUL_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
      // The last tag stage lines up with mul_out for the op it describes.
      resp_valid <= tag_vld[MUL_LAT];
      if (tag_vld[MUL_LAT]) begin
        resp_id   <= tag_id[MUL_LAT];
        resp_data <= mul_out;
      end
    end
  end

  // Control FSM; idle is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idle  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid && !hold) begin
            state <= RUN;
            idle  <= 1'b0;
          end
        end
        RUN: begin
          if (hold) begin
            state <= DRAIN;
            idle  <= 1'b0;
          end else if (!(|req_valid) && !pipe_busy) begin
            state <= IDLE;
            idle  <= 1'b1;
          end
        end
        DRAIN: begin
          if (!pipe_busy) begin
            state <= IDLE;
            idle  <= 1'b1;
          end else if (!hold) begin
            state <= RUN;
            idle  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule
